// File: rtl/ir_nec_tx.sv
// ir_nec_tx: NEC infrared frame transmitter.
// Sends a 9 ms leader mark, a 4.5 ms leader space, 32 bits LSB first
// (560 us mark + 560/1690 us space), then a 560 us stop mark.
// Optional macro IR_TX_CARRIER_EN modulates the marks with a carrier of
// half-period CARRIER_HALF clocks. Without it, ir_out is the envelope.
module ir_nec_tx #(
  parameter int unsigned CLK_PER_US   = 100,
  parameter int unsigned CARRIER_HALF = 1316
) (
  input  logic        clk,
  input  logic        reset_p,
  input  logic        start,
  input  logic [31:0] data,
  output logic        ir_out,
  output logic        busy,
  output logic        done
);

  localparam int unsigned PRE_W = (CLK_PER_US > 1) ? $clog2(CLK_PER_US) : 1;
  localparam int unsigned US_W  = 14;
  localparam int unsigned IDX_W = 5;

  localparam logic [US_W-1:0] LEAD_MARK_US  = US_W'(9000);
  localparam logic [US_W-1:0] LEAD_SPACE_US = US_W'(4500);
  localparam logic [US_W-1:0] BIT_MARK_US   = US_W'(560);
  localparam logic [US_W-1:0] ZERO_SPACE_US = US_W'(560);
  localparam logic [US_W-1:0] ONE_SPACE_US  = US_W'(1690);
  localparam logic [US_W-1:0] STOP_MARK_US  = US_W'(560);

  // Reject parameter values that would make the timing counters meaningless.
  if (CLK_PER_US == 0 || CARRIER_HALF == 0) begin : g_bad_param
    $error("ir_nec_tx: CLK_PER_US and CARRIER_HALF must be non-zero");
  end

  typedef enum logic [2:0] {
    S_IDLE       = 3'd0,
    S_LEAD_MARK  = 3'd1,
    S_LEAD_SPACE = 3'd2,
    S_BIT_MARK   = 3'd3,
    S_BIT_SPACE  = 3'd4,
    S_STOP_MARK  = 3'd5
  } state_t;

  state_t            state_q, state_d;
  logic [PRE_W-1:0]  pre_q, pre_d;
  logic [US_W-1:0]   us_q, us_d;
  logic [31:0]       shift_q, shift_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic              ir_out_q, ir_out_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic [US_W-1:0]   dur_c;
  logic              expired_c;
  logic              entering_c;
  logic              mark_d_c;

`ifdef IR_TX_CARRIER_EN
  localparam int unsigned CAR_W = (CARRIER_HALF > 1) ? $clog2(CARRIER_HALF) : 1;
  logic [CAR_W-1:0] car_q, car_d;
  logic             phase_q, phase_d;
`endif

  // Duration of the current state in microseconds and its expiry strobe.
  always_comb begin
    dur_c = US_W'(1);
    case (state_q)
      S_LEAD_MARK:  dur_c = LEAD_MARK_US;
      S_LEAD_SPACE: dur_c = LEAD_SPACE_US;
      S_BIT_MARK:   dur_c = BIT_MARK_US;
      S_BIT_SPACE:  dur_c = shift_q[0] ? ONE_SPACE_US : ZERO_SPACE_US;
      S_STOP_MARK:  dur_c = STOP_MARK_US;
      default:      dur_c = US_W'(1);
    endcase
    expired_c = (pre_q == PRE_W'(CLK_PER_US - 1)) && (us_q == dur_c - US_W'(1));
  end

  // State register.
  always_ff @(posedge clk or posedge reset_p) begin
    if (reset_p) state_q <= S_IDLE;
    else         state_q <= state_d;
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:       if (start)     state_d = S_LEAD_MARK;
      S_LEAD_MARK:  if (expired_c) state_d = S_LEAD_SPACE;
      S_LEAD_SPACE: if (expired_c) state_d = S_BIT_MARK;
      S_BIT_MARK:   if (expired_c) state_d = S_BIT_SPACE;
      S_BIT_SPACE:  if (expired_c) state_d = (idx_q == IDX_W'(31)) ? S_STOP_MARK : S_BIT_MARK;
      S_STOP_MARK:  if (expired_c) state_d = S_IDLE;
      default:                     state_d = S_IDLE;
    endcase
  end

  // Timers restart on every state entry; payload shifts after each bit space.
  always_comb begin
    pre_d      = pre_q;
    us_d       = us_q;
    shift_d    = shift_q;
    idx_d      = idx_q;
    entering_c = (state_d != state_q);
    if (entering_c || state_q == S_IDLE) begin
      pre_d = '0;
      us_d  = '0;
    end else if (pre_q == PRE_W'(CLK_PER_US - 1)) begin
      pre_d = '0;
      us_d  = us_q + US_W'(1);
    end else begin
      pre_d = pre_q + PRE_W'(1);
    end
    if (state_q == S_IDLE && start) begin
      shift_d = data;
      idx_d   = '0;
    end else if (state_q == S_BIT_SPACE && expired_c) begin
      shift_d = {1'b0, shift_q[31:1]};
      idx_d   = idx_q + IDX_W'(1);
    end
  end

`ifdef IR_TX_CARRIER_EN
  // Carrier phase restarts high on entry to each mark state.
  always_comb begin
    car_d   = car_q;
    phase_d = phase_q;
    if (!mark_d_c) begin
      car_d   = '0;
      phase_d = 1'b0;
    end else if (entering_c) begin
      car_d   = '0;
      phase_d = 1'b1;
    end else if (car_q == CAR_W'(CARRIER_HALF - 1)) begin
      car_d   = '0;
      phase_d = ~phase_q;
    end else begin
      car_d   = car_q + CAR_W'(1);
    end
  end
`endif

  // Output logic, computed from the next state so the flops line up with it.
  always_comb begin
    mark_d_c = (state_d == S_LEAD_MARK) || (state_d == S_BIT_MARK) ||
               (state_d == S_STOP_MARK);
    busy_d   = (state_d != S_IDLE);
    done_d   = (state_q == S_STOP_MARK) && (state_d == S_IDLE);
`ifdef IR_TX_CARRIER_EN
    ir_out_d = mark_d_c && phase_d;
`else
    ir_out_d = mark_d_c;
`endif
  end

  // Datapath and output registers.
  always_ff @(posedge clk or posedge reset_p) begin
    if (reset_p) begin
      pre_q    <= '0;
      us_q     <= '0;
      shift_q  <= '0;
      idx_q    <= '0;
      ir_out_q <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
`ifdef IR_TX_CARRIER_EN
      car_q    <= '0;
      phase_q  <= 1'b0;
`endif
    end else begin
      pre_q    <= pre_d;
      us_q     <= us_d;
      shift_q  <= shift_d;
      idx_q    <= idx_d;
      ir_out_q <= ir_out_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
`ifdef IR_TX_CARRIER_EN
      car_q    <= car_d;
      phase_q  <= phase_d;
`endif
    end
  end

  assign ir_out = ir_out_q;
  assign busy   = busy_q;
  assign done   = done_q;

endmodule

// File: tb/tb_ir_nec_tx.sv
// tb_ir_nec_tx: self-checking bench for ir_nec_tx at CLK_PER_US=1.
module tb_ir_nec_tx;

`ifdef IR_TX_CARRIER_EN
  localparam int CH = 13;
`else
  localparam int CH = 1316;
`endif
  localparam int NSEG = 67;

  logic        clk = 1'b0;
  logic        reset_p;
  logic        start;
  logic [31:0] data;
  logic        ir_out, busy, done;

  int checks = 0;
  int errors = 0;

  ir_nec_tx #(.CLK_PER_US(1), .CARRIER_HALF(CH)) dut (
    .clk(clk), .reset_p(reset_p), .start(start), .data(data),
    .ir_out(ir_out), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  // ---------------- behavioural model: frame as a list of segments ----------
  int  seg_len  [NSEG];
  bit  seg_mark [NSEG];
  int  m_len    = 0;
  int  m_off    = 0;
  bit  m_active = 1'b0;
  bit  m_done   = 1'b0;

  task automatic build_frame(input logic [31:0] d);
    seg_len[0] = 9000; seg_mark[0] = 1'b1;
    seg_len[1] = 4500; seg_mark[1] = 1'b0;
    for (int i = 0; i < 32; i++) begin
      seg_len[2 + 2*i] = 560;                 seg_mark[2 + 2*i] = 1'b1;
      seg_len[3 + 2*i] = d[i] ? 1690 : 560;   seg_mark[3 + 2*i] = 1'b0;
    end
    seg_len[66] = 560; seg_mark[66] = 1'b1;
    m_len = 0;
    for (int s = 0; s < NSEG; s++) m_len += seg_len[s];
  endtask

  function automatic bit exp_ir(input int k);
    int acc = 0;
    bit r   = 1'b0;
    bit hit = 1'b0;
    for (int s = 0; s < NSEG; s++) begin
      if (!hit && k < acc + seg_len[s]) begin
        hit = 1'b1;
`ifdef IR_TX_CARRIER_EN
        r = seg_mark[s] && (((k - acc) / CH) % 2 == 0);
`else
        r = seg_mark[s];
`endif
      end
      acc += seg_len[s];
    end
    return r;
  endfunction

  // Model advance: one frame offset per clock, start taken only when idle.
  always @(posedge clk or posedge reset_p) begin
    if (reset_p) begin
      m_active = 1'b0;
      m_done   = 1'b0;
    end else begin
      m_done = m_active && (m_off == m_len - 1);
      if (m_active) begin
        if (m_off == m_len - 1) m_active = 1'b0;
        else                    m_off++;
      end else if (start) begin
        build_frame(data);
        m_active = 1'b1;
        m_off    = 0;
      end
    end
  end

  // Per-cycle comparison of DUT outputs against the model.
  always @(negedge clk) begin
    logic [2:0] exp_v, act_v;
    exp_v = {m_active ? exp_ir(m_off) : 1'b0, m_active, m_done};
    act_v = {ir_out, busy, done};
    checks++;
    if (act_v !== exp_v) begin
      errors++;
      $display("FAIL cycle_model t=%0t: {ir,busy,done} got %b expected %b", $time, act_v, exp_v);
    end
  end

  // ---------------- run-length recorder for literal checks ------------------
  int q_runs[$];
  int fr_runs[$];
  int cur_len = 0, bcnt = 0, idle_cnt = 0, last_gap = 0;
  bit cur_lvl = 1'b0, prev_busy = 1'b0;
  int fr_len = 0, fr_gap = 0, frames_done = 0, done_cnt = 0;
  bit smp[4];
  bit fr_smp[4];

  always @(negedge clk) begin
    if (done === 1'b1) done_cnt++;
    if (busy === 1'b1) begin
      if (!prev_busy) begin
        q_runs.delete();
        cur_lvl  = ir_out;
        cur_len  = 1;
        bcnt     = 1;
        last_gap = idle_cnt;
      end else begin
        bcnt++;
        if (ir_out == cur_lvl) cur_len++;
        else begin
          q_runs.push_back(cur_lvl ? cur_len : -cur_len);
          cur_lvl = ir_out;
          cur_len = 1;
        end
      end
      case (bcnt - 1)
        13000:   smp[0] = ir_out;
        13500:   smp[1] = ir_out;
        13512:   smp[2] = ir_out;
        13513:   smp[3] = ir_out;
        default: ;
      endcase
      idle_cnt = 0;
    end else begin
      if (prev_busy) begin
        q_runs.push_back(cur_lvl ? cur_len : -cur_len);
        fr_runs = q_runs;
        fr_len  = bcnt;
        fr_gap  = last_gap;
        fr_smp  = smp;
        frames_done++;
      end
      idle_cnt++;
    end
    prev_busy = (busy === 1'b1);
  end

  // ---------------- helpers ----------------------------------------------------
  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic wait_frames(input int target, input int budget, input string what);
    int n = 0;
    while (frames_done < target && n < budget) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (frames_done < target) begin
      errors++;
      $display("FAIL %s: frames_done got %0d expected %0d within %0d cycles", what, frames_done, target, budget);
    end
  endtask

  task automatic pulse_start(input logic [31:0] d);
    data  = d;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  // ---------------- directed stimulus -----------------------------------------
  initial begin
    int base;
    int bad;
    logic [31:0] word;
    reset_p = 1'b1;
    start   = 1'b0;
    data    = '0;
    repeat (3) @(negedge clk);
    chk("reset_ir_out", int'(ir_out), 0);
    chk("reset_busy",   int'(busy),   0);
    chk("reset_done",   int'(done),   0);
    #2 reset_p = 1'b0;
    repeat (3) @(negedge clk);

    // Abort a frame with reset during the first bit space (bit0=1 -> 1690 cycles).
    pulse_start(32'hA5A5_A5A5);
    repeat (14100) @(negedge clk);
    #2 reset_p = 1'b1;
    #1;
    chk("midreset_ir_out", int'(ir_out), 0);
    chk("midreset_busy",   int'(busy),   0);
    repeat (3) @(negedge clk);
    #2 reset_p = 1'b0;
    repeat (20) @(negedge clk);
    chk("post_reset_idle_busy", int'(busy), 0);
    chk("post_reset_no_done",   done_cnt,   0);

    // Frame A: 00FF00FF with an ignored re-start and new data at ~1000 cycles.
    base = frames_done;
    pulse_start(32'h00FF_00FF);
    repeat (999) @(negedge clk);
    pulse_start(32'hFFFF_FFFF);
    repeat (66000) @(negedge clk);
    data  = 32'h0000_0001;
    start = 1'b1;
    wait_frames(base + 1, 3000, "frameA_end");
    chk("A_busy_len",  fr_len,   67980);
    chk("A_done_once", done_cnt, 1);
    chk("A_lead_space_ir", int'(fr_smp[0]), 0);
    chk("A_bitmark_c0",    int'(fr_smp[1]), 1);
    chk("A_bitmark_c12",   int'(fr_smp[2]), 1);
`ifdef IR_TX_CARRIER_EN
    chk("A_bitmark_c13",   int'(fr_smp[3]), 0);
`else
    chk("A_bitmark_c13",   int'(fr_smp[3]), 1);
    chk("A_run_count",     fr_runs.size(), NSEG);
    chk("A_lead_mark",     fr_runs[0], 9000);
    chk("A_lead_space",    fr_runs[1], -4500);
    word = '0;
    for (int i = 0; i < 32; i++) word[i] = (fr_runs[3 + 2*i] == -1690);
    chk("A_decoded_bits",  int'(word), int'(32'h00FF_00FF));
`endif

    // Frame B follows with start held high: one idle cycle gap.
    @(negedge clk);
    @(negedge clk);
    start = 1'b0;
    wait_frames(base + 2, 60000, "frameB_end");
    chk("B_busy_len", fr_len,   51030);
    chk("B_gap",      fr_gap,   1);
    chk("B_done_cnt", done_cnt, 2);
`ifndef IR_TX_CARRIER_EN
    chk("B_first_space", fr_runs[3], -1690);
    bad = 0;
    for (int i = 1; i < 32; i++) if (fr_runs[3 + 2*i] != -560) bad++;
    chk("B_other_spaces_560", bad, 0);
`endif

    repeat (10) @(negedge clk);
    chk("final_idle_busy", int'(busy), 0);
    chk("final_done_cnt",  done_cnt,   2);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
